// File: rtl/mips_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_pkg
// Description : Shared types and constants for the MIPS Avalon bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_M0 = 3'd1,
        BUSY_M1 = 3'd2,
        RESP_M0 = 3'd3,
        RESP_M1 = 3'd4
    } arb_state_t;

    localparam logic        MASTER_INSTR = 1'b0;
    localparam logic        MASTER_DATA  = 1'b1;
    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage : mips_bus_pkg
`default_nettype wire

// File: rtl/mips_bus_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_rr_pick
// Description : Combinational two-way round-robin picker, one-hot winner.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_winner
);

    always_comb begin
        o_winner = 2'b00;
        if (i_req == 2'b11) begin
            // Tie: whoever was not served last goes next.
            o_winner = (i_last_grant == MASTER_DATA) ? 2'b01 : 2'b10;
        end else begin
            o_winner = i_req;
        end
    end

endmodule : mips_bus_rr_pick
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_arbiter
// Description : Two-master (fetch/data) to one-slave Avalon-MM bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_read,
    input  logic [31:0] m0_address,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_address,
    input  logic [3:0]  m1_byteenable,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic        read,
    output logic        write,
    output logic [31:0] address,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam logic [31:0] c_timeout = 32'(TIMEOUT_CYCLES);

    arb_state_t  r_state;
    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [3:0]  r_byteenable;
    logic [31:0] r_writedata;
    logic [31:0] r_capture;
    logic [31:0] r_count;
    logic [1:0]  r_grant;
    logic        r_last_grant;
    logic        r_timeout_err;

    arb_state_t  w_state_next;
    logic        w_read_next;
    logic        w_write_next;
    logic [31:0] w_address_next;
    logic [3:0]  w_byteenable_next;
    logic [31:0] w_writedata_next;
    logic [31:0] w_capture_next;
    logic [31:0] w_count_next;
    logic [1:0]  w_grant_next;
    logic        w_last_grant_next;
    logic        w_timeout_err_next;

    logic [1:0]  w_req;
    logic [1:0]  w_winner;
    logic [31:0] w_count_inc;
    logic        w_timeout_hit;

    assign w_req = {m1_read | m1_write, m0_read};

    mips_bus_rr_pick u_rr_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    // The counter "reaches" the limit on the stalled edge that would make it
    // equal TIMEOUT_CYCLES, so BUSY lasts exactly TIMEOUT_CYCLES stalled cycles.
    assign w_count_inc   = sat_inc(r_count);
    assign w_timeout_hit = (c_timeout != 32'd0) && (w_count_inc == c_timeout);

    always_comb begin
        w_state_next       = r_state;
        w_read_next        = r_read;
        w_write_next       = r_write;
        w_address_next     = r_address;
        w_byteenable_next  = r_byteenable;
        w_writedata_next   = r_writedata;
        w_capture_next     = r_capture;
        w_count_next       = r_count;
        w_grant_next       = r_grant;
        w_last_grant_next  = r_last_grant;
        w_timeout_err_next = r_timeout_err;

        case (r_state)
            IDLE: begin
                w_read_next       = 1'b0;
                w_write_next      = 1'b0;
                w_address_next    = 32'd0;
                w_byteenable_next = 4'd0;
                w_writedata_next  = 32'd0;
                w_grant_next      = 2'b00;
                if (w_winner[0]) begin
                    w_state_next      = BUSY_M0;
                    w_read_next       = 1'b1;
                    w_address_next    = m0_address;
                    w_byteenable_next = 4'hF;
                    w_grant_next      = 2'b01;
                    w_count_next      = 32'd0;
                end else if (w_winner[1]) begin
                    w_state_next      = BUSY_M1;
                    w_read_next       = ~m1_write;
                    w_write_next      = m1_write;
                    w_address_next    = m1_address;
                    w_byteenable_next = m1_byteenable;
                    w_writedata_next  = m1_writedata;
                    w_grant_next      = 2'b10;
                    w_count_next      = 32'd0;
                end
            end

            BUSY_M0, BUSY_M1: begin
                if (!waitrequest || w_timeout_hit) begin
                    w_state_next      = (r_state == BUSY_M0) ? RESP_M0 : RESP_M1;
                    w_last_grant_next = (r_state == BUSY_M0) ? MASTER_INSTR : MASTER_DATA;
                    w_read_next       = 1'b0;
                    w_write_next      = 1'b0;
                    w_address_next    = 32'd0;
                    w_byteenable_next = 4'd0;
                    w_writedata_next  = 32'd0;
                    if (!waitrequest) begin
                        w_capture_next = r_write ? 32'd0 : readdata;
                    end else begin
                        w_capture_next     = BUS_ERR_DATA;
                        w_timeout_err_next = 1'b1;
                    end
                end else begin
                    w_count_next = w_count_inc;
                end
            end

            RESP_M0, RESP_M1: begin
                w_state_next      = IDLE;
                w_grant_next      = 2'b00;
                w_read_next       = 1'b0;
                w_write_next      = 1'b0;
                w_address_next    = 32'd0;
                w_byteenable_next = 4'd0;
                w_writedata_next  = 32'd0;
            end

            default: begin
                w_state_next = IDLE;
                w_grant_next = 2'b00;
                w_read_next  = 1'b0;
                w_write_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_address     <= 32'd0;
            r_byteenable  <= 4'd0;
            r_writedata   <= 32'd0;
            r_capture     <= 32'd0;
            r_count       <= 32'd0;
            r_grant       <= 2'b00;
            r_last_grant  <= MASTER_DATA;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_read        <= w_read_next;
            r_write       <= w_write_next;
            r_address     <= w_address_next;
            r_byteenable  <= w_byteenable_next;
            r_writedata   <= w_writedata_next;
            r_capture     <= w_capture_next;
            r_count       <= w_count_next;
            r_grant       <= w_grant_next;
            r_last_grant  <= w_last_grant_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    // Master-side handshake depends on the state register alone.
    assign m0_waitrequest = (r_state != RESP_M0);
    assign m1_waitrequest = (r_state != RESP_M1);
    assign m0_readdata    = (r_state == RESP_M0) ? r_capture : 32'd0;
    assign m1_readdata    = (r_state == RESP_M1) ? r_capture : 32'd0;

    assign read        = r_read;
    assign write       = r_write;
    assign address     = r_address;
    assign byteenable  = r_byteenable;
    assign writedata   = r_writedata;
    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

endmodule : mips_bus_arbiter
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_bus_arbiter
// Description : Directed self-checking bench for mips_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_read = 1'b0;
    logic [31:0] m0_address = 32'd0;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_address = 32'd0;
    logic [3:0]  m1_byteenable = 4'd0;
    logic [31:0] m1_writedata = 32'd0;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = 32'd0;
    logic [1:0]  grant;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_read        (m0_read),
        .m0_address     (m0_address),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_address     (m1_address),
        .m1_byteenable  (m1_byteenable),
        .m1_writedata   (m1_writedata),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .read           (read),
        .write          (write),
        .address        (address),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .waitrequest    (waitrequest),
        .readdata       (readdata),
        .grant          (grant),
        .timeout_err    (timeout_err)
    );

    typedef struct packed {
        logic        m;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] sdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req;
        m0_read  = 1'b0;
        m1_read  = 1'b0;
        m1_write = 1'b0;
    endtask

    task automatic do_reset;
        clear_req();
        waitrequest = 1'b0;
        reset = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   n;
        int   c0;
        int   c1;
        logic [1:0] exp_g;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1000, 4'h0, 32'h0,         32'h2402_0005, 1'b1, 1'b0, 4'hF, 32'h2402_0005};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_2004, 4'hC, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 4'hC, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_2008, 4'hF, 32'hCAFE_F00D, 32'hAAAA_5555, 1'b0, 1'b1, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_200C, 4'h1, 32'h0000_00A5, 32'h5555_AAAA, 1'b0, 1'b1, 4'h1, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h8000_0001, 1'b1, 1'b0, 4'hF, 32'h8000_0001};

        // Reset state, sampled while reset is still asserted.
        repeat (2) tick();
        chk("rst_read",   32'(read), 32'd0);
        chk("rst_write",  32'(write), 32'd0);
        chk("rst_addr",   address, 32'd0);
        chk("rst_be",     32'(byteenable), 32'd0);
        chk("rst_wdata",  writedata, 32'd0);
        chk("rst_grant",  32'(grant), 32'd0);
        chk("rst_m0_wr",  32'(m0_waitrequest), 32'd1);
        chk("rst_m1_wr",  32'(m1_waitrequest), 32'd1);
        chk("rst_m0_rd",  m0_readdata, 32'd0);
        chk("rst_m1_rd",  m1_readdata, 32'd0);
        chk("rst_terr",   32'(timeout_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Lone, unstalled transfers.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            if (v.m == 1'b0) begin
                m0_read    = v.rd;
                m0_address = v.addr;
            end else begin
                m1_read       = v.rd;
                m1_write      = v.wr;
                m1_address    = v.addr;
                m1_byteenable = v.be;
                m1_writedata  = v.wdata;
            end
            waitrequest = 1'b0;
            readdata    = v.sdata;
            tick();
            chk($sformatf("v%0d_read", i),  32'(read), 32'(v.exp_rd));
            chk($sformatf("v%0d_write", i), 32'(write), 32'(v.exp_wr));
            chk($sformatf("v%0d_addr", i),  address, v.addr);
            chk($sformatf("v%0d_be", i),    32'(byteenable), 32'(v.exp_be));
            if (v.exp_wr) chk($sformatf("v%0d_wdata", i), writedata, v.wdata);
            chk($sformatf("v%0d_grant", i), 32'(grant), v.m ? 32'd2 : 32'd1);
            chk($sformatf("v%0d_busy_wr", i), 32'(v.m ? m1_waitrequest : m0_waitrequest), 32'd1);
            tick();
            chk($sformatf("v%0d_resp_wr", i), 32'(v.m ? m1_waitrequest : m0_waitrequest), 32'd0);
            chk($sformatf("v%0d_resp_rd", i), v.m ? m1_readdata : m0_readdata, v.exp_rdata);
            chk($sformatf("v%0d_other_wr", i), 32'(v.m ? m0_waitrequest : m1_waitrequest), 32'd1);
            chk($sformatf("v%0d_resp_bus", i), 32'({read, write}), 32'd0);
            clear_req();
            tick();
            chk($sformatf("v%0d_idle_grant", i), 32'(grant), 32'd0);
            chk($sformatf("v%0d_idle_wr", i), 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
        end

        // Simultaneous requests right after reset: m0, then m1, then m0.
        do_reset();
        m0_read       = 1'b1;
        m0_address    = 32'h0000_1004;
        m1_write      = 1'b1;
        m1_address    = 32'h0000_2000;
        m1_byteenable = 4'b0011;
        m1_writedata  = 32'hDEAD_BEEF;
        readdata      = 32'h1111_1111;
        tick();
        chk("tie1_grant", 32'(grant), 32'd1);
        chk("tie1_addr",  address, 32'h0000_1004);
        chk("tie1_read",  32'(read), 32'd1);
        tick();
        chk("tie1_m0_wr", 32'(m0_waitrequest), 32'd0);
        chk("tie1_m0_rd", m0_readdata, 32'h1111_1111);
        chk("tie1_m1_wr", 32'(m1_waitrequest), 32'd1);
        m0_address = 32'h0000_1008;
        tick();
        chk("tie1_idle", 32'(grant), 32'd0);
        tick();
        chk("tie2_grant", 32'(grant), 32'd2);
        chk("tie2_write", 32'(write), 32'd1);
        chk("tie2_read",  32'(read), 32'd0);
        chk("tie2_addr",  address, 32'h0000_2000);
        chk("tie2_be",    32'(byteenable), 32'd3);
        chk("tie2_wdata", writedata, 32'hDEAD_BEEF);
        tick();
        chk("tie2_m1_wr", 32'(m1_waitrequest), 32'd0);
        chk("tie2_m1_rd", m1_readdata, 32'd0);
        m1_write = 1'b0;
        tick();
        tick();
        chk("tie3_grant", 32'(grant), 32'd1);
        chk("tie3_addr",  address, 32'h0000_1008);
        tick();
        chk("tie3_m0_wr", 32'(m0_waitrequest), 32'd0);
        clear_req();
        tick();

        // Slave stall of 5 cycles on an m1 read.
        m1_read       = 1'b1;
        m1_address    = 32'h0000_3000;
        m1_byteenable = 4'hF;
        waitrequest   = 1'b1;
        readdata      = 32'h0BAD_CAFE;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("stall%0d_read", i), 32'(read), 32'd1);
            chk($sformatf("stall%0d_addr", i), address, 32'h0000_3000);
            chk($sformatf("stall%0d_m1_wr", i), 32'(m1_waitrequest), 32'd1);
            if (i == 5) waitrequest = 1'b0;
            tick();
        end
        chk("stall_resp_wr", 32'(m1_waitrequest), 32'd0);
        chk("stall_resp_rd", m1_readdata, 32'h0BAD_CAFE);
        clear_req();
        tick();
        chk("stall_after_wr", 32'(m1_waitrequest), 32'd1);

        // Timeout: slave never answers; abort after 8 stalled cycles.
        m1_read     = 1'b1;
        m1_address  = 32'h0000_4000;
        waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to%0d_read", i), 32'(read), 32'd1);
            chk($sformatf("to%0d_m1_wr", i), 32'(m1_waitrequest), 32'd1);
            tick();
        end
        chk("to_resp_wr",  32'(m1_waitrequest), 32'd0);
        chk("to_resp_rd",  m1_readdata, 32'hFFFF_FFFF);
        chk("to_err",      32'(timeout_err), 32'd1);
        chk("to_bus_off",  32'({read, write}), 32'd0);
        clear_req();
        waitrequest = 1'b0;
        tick();
        chk("to_err_idle", 32'(timeout_err), 32'd1);
        m0_read    = 1'b1;
        m0_address = 32'h0000_1010;
        readdata   = 32'h0000_0042;
        tick();
        chk("to_next_read", 32'(read), 32'd1);
        tick();
        chk("to_next_wr", 32'(m0_waitrequest), 32'd0);
        chk("to_next_rd", m0_readdata, 32'h0000_0042);
        clear_req();
        tick();
        chk("to_err_kept", 32'(timeout_err), 32'd1);

        // Reset while BUSY_M1.
        m1_write     = 1'b1;
        m1_address   = 32'h0000_5000;
        m1_writedata = 32'h0000_0001;
        waitrequest  = 1'b1;
        tick();
        chk("mrst_busy_write", 32'(write), 32'd1);
        chk("mrst_busy_grant", 32'(grant), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_write", 32'(write), 32'd0);
        chk("mrst_read",  32'(read), 32'd0);
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_wr",    32'({m1_waitrequest, m0_waitrequest}), 32'd3);
        chk("mrst_terr",  32'(timeout_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("mrst_hold%0d_wr", i), 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
        end
        clear_req();
        waitrequest = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mrst_post%0d_wr", i), 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
            chk($sformatf("mrst_post%0d_grant", i), 32'(grant), 32'd0);
        end

        // Back-to-back fairness with both masters always requesting.
        do_reset();
        m0_read      = 1'b1;
        m0_address   = 32'h0000_0100;
        m1_write     = 1'b1;
        m1_address   = 32'h0000_0200;
        m1_writedata = 32'h0000_0055;
        readdata     = 32'h0000_0007;
        c0 = 0;
        c1 = 0;
        for (int t = 0; t < 20; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (grant == 2'b00 && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("fair%0d_grant", t), 32'(grant), 32'(exp_g));
            n = 0;
            while (m0_waitrequest && m1_waitrequest && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("fair%0d_done", t), 32'(n < 10), 32'd1);
            if (!m0_waitrequest) c0++;
            if (!m1_waitrequest) c1++;
            tick();
        end
        chk("fair_m0_count", 32'(c0), 32'd10);
        chk("fair_m1_count", 32'(c1), 32'd10);
        clear_req();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_bus_arbiter
`default_nettype wire

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the CPU's Avalon memory-mapped bus. It shares a single Avalon slave port between the Harvard core's instruction-fetch master (m0, read-only) and data master (m1, read/write). Each winning transfer is registered onto the shared bus and held until the slave drops `waitrequest`. The result is then returned to the winner as a one-cycle, `waitrequest`-low completion. It sits between `mips_cpu_harvard` and the memory/peripheral interconnect, and replaces ad-hoc fetch/data muxing in bus wrappers.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles a transfer may stall on slave `waitrequest` before abort; 0 disables the timeout.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m0_read` in 1: instruction-fetch read request.
- `m0_address` in 32: fetch address.
- `m0_waitrequest` out 1: low for exactly one cycle when the m0 transfer completes.
- `m0_readdata` out 32: fetch data, valid while `m0_waitrequest` is low.
- `m1_read` in 1: data read request.
- `m1_write` in 1: data write request.
- `m1_address` in 32: data address.
- `m1_byteenable` in 4: byte lanes.
- `m1_writedata` in 32: write data.
- `m1_waitrequest` out 1: low for exactly one cycle when the m1 transfer completes.
- `m1_readdata` out 32: read data, valid while `m1_waitrequest` is low.
- `read` out 1: shared-bus read strobe.
- `write` out 1: shared-bus write strobe.
- `address` out 32: shared-bus address.
- `byteenable` out 4: shared-bus byte lanes.
- `writedata` out 32: shared-bus write data.
- `waitrequest` in 1: slave stall.
- `readdata` in 32: slave read data.
- `grant` out 2: one-hot owner of the bus ({m1,m0}); 00 when idle.
- `timeout_err` out 1: sticky; set on any aborted transfer.

## Operation
- States: IDLE, BUSY_M0, BUSY_M1, RESP_M0, RESP_M1.
- **IDLE:** if any request is present, pick a winner, latch its command into the bus registers, and go to BUSY_x.
  - m0 commands latch as read, byteenable 4'hF.
  - m1 asserting both `m1_read` and `m1_write` is treated as a write.
- **Arbitration:** round-robin on a `last_grant` register. On a tie, the master not granted last wins. `last_grant` resets to m1, so m0 wins the first tie. A lone requester always wins.
- **BUSY_x:** the bus is driven from the registers, and the timeout counter increments each cycle.
  - On `waitrequest`=0: capture `readdata` (0 for writes), go to RESP_x, update `last_grant`.
  - If the counter reaches `TIMEOUT_CYCLES`: deassert the bus, set `timeout_err`, capture 32'hFFFF_FFFF, go to RESP_x.
- **RESP_x:** `mx_waitrequest`=0, `mx_readdata` = captured value; next state is IDLE.
- `mx_waitrequest` = 1 in every state except RESP_x, whether or not the master is requesting.
- If a master drops its request during BUSY (Avalon violation), the bus transfer still completes. The RESP cycle is still issued, and its result is ignored.
- Bus command registers are cleared in IDLE and RESP; `read` and `write` are never both high.
- `timeout_err` clears only on reset.

## Timing
- **Reset (async assert):** state IDLE.
  - All bus outputs 0; `grant`=00; both `mx_waitrequest`=1; both `mx_readdata`=0.
  - `timeout_err`=0; counter 0; `last_grant`=m1.
- **Reset deassert:** arbitration starts on the first rising edge after deassertion.
- **Reset mid-transfer:** the bus strobe drops immediately (async) and no completion is issued.
- **Minimum latency,** request at edge N with slave `waitrequest`=0:
  - Bus strobe visible N+1.
  - RESP (master `waitrequest` low) N+2.
  - IDLE N+3.
  - Throughput is 1 transfer per 3 cycles.
- **Slave stall:** each cycle of slave `waitrequest`=1 adds one cycle in BUSY.
- **Timeout:** abort on the cycle the counter equals `TIMEOUT_CYCLES`, i.e. after exactly `TIMEOUT_CYCLES` stalled cycles.
- **Counter:** 32-bit, saturating; reset to 0 on entry to BUSY.
- **Output timing:**
  - `grant` is registered and tracks BUSY/RESP.
  - Master `waitrequest` is decoded from the state register only; no combinational path from bus inputs.

## Structure
- Shared package `mips_bus_pkg` holds:
  - `arb_state_t` enum (3-bit: IDLE, BUSY_M0, BUSY_M1, RESP_M0, RESP_M1).
  - Master ID constants `MASTER_INSTR`=0 and `MASTER_DATA`=1.
  - `BUS_ERR_DATA`=32'hFFFF_FFFF.
- One sub-module is natural: `mips_bus_rr_pick`, the combinational 2-way round-robin picker (inputs: requests, `last_grant`; output: one-hot winner). Everything else lives in the top module.

## Test plan
- **Lone m0 read:** m0 read of 0x0000_1000; slave returns 0x2402_0005 with no stall.
  - `read`=1 and `address`=0x1000 at N+1.
  - `m0_waitrequest`=0 with `m0_readdata`=0x2402_0005 at N+2.
- **Simultaneous requests after reset:** m0 read 0x1004 and m1 write 0x2000 (data 0xDEAD_BEEF, be 4'b0011).
  - m0 is served first; m1's write appears on the bus at N+4 with be 4'b0011.
  - A second tie then goes to m1.
- **Slave stall:** slave holds `waitrequest` for 5 cycles on an m1 read.
  - The bus stays stable for 6 cycles.
  - `m1_waitrequest` goes low exactly once, with the correct data.
- **Timeout:** `TIMEOUT_CYCLES`=8, slave stalls forever.
  - Abort after 8 stalled cycles.
  - `m1_readdata`=0xFFFF_FFFF; `timeout_err`=1 and stays 1.
  - The next transfer completes normally.
- **Reset mid-transfer:** assert reset in BUSY_M1.
  - `write`/`read` drop asynchronously; `grant`=00; no `waitrequest`-low pulse on either master.
- **Back-to-back fairness:** both masters request continuously for 20 transfers.
  - Grants strictly alternate m0, m1, m0, …; 10 completions each.
